// File: rtl/alu_pkg.sv
// Shared types and default sizing for the chunked sequential adder/subtractor.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/alu_add_seq_add_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB
// so the top level can derive signed overflow on the final slice.
module add_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s    = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // The MSB sum bit is a^b^carry_in, so the carry in falls out by XOR.
  assign cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/alu_add_seq.sv
// Sequential WIDTH-bit add/subtract, CHUNK bits per cycle, with valid/ready
// handshakes on both sides and carry/overflow/zero flags.
module alu_add_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N    = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("alu_add_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e                      state_q, state_d;
  logic [N-1:0][CHUNK-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        cy_q, cy_d;
  logic                        carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CHUNK-1:0]            s_ch;
  logic                        c_out, c_msb;

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (cy_q),
    .s    (s_ch),
    .cout (c_out),
    .cmsb (c_msb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction as in1 + ~in2 + 1: the +1 enters as the initial carry.
          a_d     = in1;
          b_d     = sub ? ~in2 : in2;
          cy_d    = sub;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[idx_q] = s_ch;
        cy_d         = c_out;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST) begin
          carry_d = c_out;
          ovf_d   = c_out ^ c_msb;
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_add_seq.sv
// Directed bench for alu_add_seq: default 32/8 instance plus a 16/16 instance.
module tb_alu_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic        in_ready, out_valid, carry, overflow, zero;
  logic [31:0] sum;

  logic        w_in_valid = 1'b0, w_sub = 1'b0, w_out_ready = 1'b0;
  logic [15:0] w_in1 = '0, w_in2 = '0;
  logic        w_in_ready, w_out_valid, w_carry, w_overflow, w_zero;
  logic [15:0] w_sum;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned lat;

  always #5 clk = ~clk;

  alu_add_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
  );

  alu_add_seq #(.WIDTH(16), .CHUNK(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .sub(w_sub),
    .in1(w_in1), .in2(w_in2), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .carry(w_carry), .overflow(w_overflow), .zero(w_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the accepting edge until out_valid, bounded.
  task automatic wait_result(input string tag, input int unsigned exp_lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_flags(input string tag, input logic [31:0] es,
                             input logic ec, input logic eo, input logic ez);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_carry"}, {31'b0, carry}, {31'b0, ec});
    chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, eo});
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovalid_fall"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_iready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] es,
                       input logic ec, input logic eo, input logic ez);
    chk({tag, "_iready"}, {31'b0, in_ready}, 32'd1);
    in1 = a; in2 = b; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(tag, 4);
    check_flags(tag, es, ec, eo, ez);
    handshake(tag);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {29'b0, carry, overflow, zero}, 32'd0);
    chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("rst_iready", {31'b0, in_ready}, 32'd1);
    chk("w_rst_iready", {31'b0, w_in_ready}, 32'd1);
    chk("w_rst_sum", {16'b0, w_sum}, 32'd0);

    do_op("wrap",   32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0,         1'b1, 1'b0, 1'b1);
    do_op("sovf",   32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op("sub1",   32'd555,       32'd246, 1'b1, 32'd309,     1'b1, 1'b0, 1'b0);
    do_op("borrow", 32'd0,         32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op("subeq",  32'd5,         32'd5, 1'b1, 32'd0,         1'b1, 1'b0, 1'b1);
    do_op("subovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op("mixed",  32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held, new operands wait until IDLE.
    in1 = 32'd3; in2 = 32'd4; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result("bp", 4);
    in1 = 32'd100; in2 = 32'd200; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ovalid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_iready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_sum", sum, 32'd7);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_iready", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_sum", sum, 32'd7);
    tick();
    in_valid = 1'b0;
    wait_result("bp_next", 4);
    check_flags("bp_next", 32'd300, 1'b0, 1'b0, 1'b0);
    handshake("bp_next");

    // Reset in the second CALC cycle discards the operation.
    in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_iready", {31'b0, in_ready}, 32'd1);
    chk("mrst_sum", sum, 32'd0);
    chk("mrst_flags", {29'b0, carry, overflow, zero}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("mrst_no_ovalid", {31'b0, out_valid}, 32'd0);
      tick();
    end
    do_op("after_rst", 32'd6, 32'd9, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0);

    // Single-chunk instance: result one cycle after accept.
    w_in1 = 16'hFFFF; w_in2 = 16'h0002; w_sub = 1'b0; w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("w_lat", lat, 32'd1);
    chk("w_sum", {16'b0, w_sum}, 32'h0001);
    chk("w_carry", {31'b0, w_carry}, 32'd1);
    chk("w_ovf", {31'b0, w_overflow}, 32'd0);
    chk("w_zero", {31'b0, w_zero}, 32'd0);
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    chk("w_iready_back", {31'b0, w_in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_add_seq.md
ALU_ADD_SEQ -- requirements
Module: alu_add_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, else elaboration error.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands and mode valid.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 sub  input  1  0 = in1+in2, 1 = in1-in2.
REQ-008 in1, in2  input  WIDTH  operands.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 carry, overflow, zero  output  1 each  unsigned carry-out, signed overflow, result==0.

Function
REQ-013 States: IDLE, CALC, DONE; N = WIDTH/CHUNK.
REQ-014 IDLE: in_ready=1; on in_valid=1, latch in1, in2 (in2 inverted when sub=1), sub; chunk index=0; running carry=sub; go to CALC.
REQ-015 CALC: each cycle adds chunk[index] of both latched operands plus running carry, writes sum chunk[index], updates running carry, increments index.
REQ-016 CALC exits to DONE on the edge that writes chunk N-1; out_valid SHALL rise exactly N cycles after the accepting edge (4 at defaults, 1 when CHUNK=WIDTH).
REQ-017 carry = carry-out of bit WIDTH-1; for sub, carry=1 means no borrow (in1>=in2 unsigned).
REQ-018 overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-019 zero = 1 iff all WIDTH sum bits are 0.
REQ-020 DONE: out_valid=1; sum and flags held stable while out_ready=0; on out_ready=1 go to IDLE, out_valid falls next cycle.
REQ-021 in_ready=0 in CALC and DONE; in_valid there is ignored, operands not sampled.
REQ-022 No combinational path from any input to any output.
REQ-023 in_ready reaches 1 the cycle after the DONE handshake; back-to-back throughput one operation per N+2 cycles.

Reset
REQ-024 rst=1 at a clock edge forces IDLE; sum=0, carry=0, overflow=0, zero=0, out_valid=0, in_ready=1 after that edge.
REQ-025 rst during CALC or DONE discards the operation; no out_valid for it.
REQ-026 rst has priority over every handshake in the same cycle.

Structure
REQ-027 Shared package alu_pkg holds the state enum (IDLE, CALC, DONE) and default WIDTH/CHUNK constants.
REQ-028 One sub-module add_chunk: combinational CHUNK-bit adder, inputs a, b, cin, outputs s, cout, plus carry into MSB for overflow on the last chunk.
REQ-029 Index counter width = clog2(N), minimum 1 bit.

Verification
REQ-030 0xFFFFFFFF + 1, sub=0 -> sum 0, carry 1, zero 1, overflow 0; out_valid 4 cycles after accept.
REQ-031 0x7FFFFFFF + 1, sub=0 -> sum 0x80000000, carry 0, overflow 1, zero 0.
REQ-032 555 - 246 -> sum 309, carry 1, overflow 0; then 0 - 1 -> sum 0xFFFFFFFF, carry 0, overflow 0.
REQ-033 Backpressure: out_ready=0 for 3 cycles in DONE, in_valid held 1 with new operands -> sum/flags stable, in_ready 0, new operands not taken until IDLE.
REQ-034 rst asserted in 2nd CALC cycle -> next cycle IDLE, in_ready 1, outputs 0, no out_valid; following 6 + 9 -> sum 15.
REQ-035 WIDTH=16, CHUNK=16: 0xFFFF + 2 -> sum 0x0001, carry 1, out_valid 1 cycle after accept.
